// File: rtl/sonar_wb_fabric_if.sv
// sonar_wb_fabric_if: Wishbone slave-port bundle between Caravel and the sonar fabric.
// The master modport drives requests; the slave modport returns ack and read data.
interface sonar_wb_fabric_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sonar_wb_fabric.sv
// sonar_wb_fabric: registered Wishbone decode/handshake to N_CH sonar channels plus local regs.
// Define SONAR_FABRIC_TIMEOUT_EN to abort a channel that does not ack within TIMEOUT cycles.
module sonar_wb_fabric #(
  parameter int N_CH    = 15,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  sonar_wb_fabric_if.slave   wbs,
  output logic [N_CH-1:0]    ch_valid_o,
  output logic [3:0]         ch_adr_o,
  output logic [DW-1:0]      ch_dat_o,
  output logic               ch_strb_o,
  input  logic [N_CH-1:0]    ch_ack_i,
  input  logic [N_CH*DW-1:0] ch_dat_i,
  input  logic [N_CH-1:0]    cmp_i,
  output logic [7:0]         prescaler_o,
  output logic               irq_o
);

  localparam logic [31:0] CH_MASK =
    32'((64'd1 << N_CH) - 64'd1);
  localparam logic [31:0] MSK_BITS =
    CH_MASK | 32'h8000_0000;
`ifdef SONAR_FABRIC_TIMEOUT_EN
  localparam logic [31:0] STAT_MASK = MSK_BITS;
  localparam int TW = $clog2(TIMEOUT + 1);
`else
  localparam logic [31:0] STAT_MASK = CH_MASK;
`endif
  localparam logic [5:0] NCH6 = 6'(N_CH);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CH_WAIT,
    S_DONE
  } state_t;

  state_t r_state, w_nxt;

  logic            r_ack;
  logic [31:0]     r_dat;
  logic [N_CH-1:0] r_valid;
  logic [3:0]      r_adr;
  logic [DW-1:0]   r_cdat;
  logic            r_strb;
  logic [31:0]     r_status;
  logic [31:0]     r_mask;
  logic [7:0]      r_presc;
  logic            r_irq;

  logic            w_req;
  logic [8:0]      w_word;
  logic [4:0]      w_blk;
  logic            w_local;
  logic            w_ch_ok;
  logic [N_CH-1:0] w_chsel;
  logic [31:0]     w_bmask;
  logic            w_is_stat;
  logic            w_is_pre;
  logic            w_is_msk;
  logic [31:0]     w_loc_rd;
  logic            w_sel_ack;
  logic [DW-1:0]   w_sel_dat;
  logic            w_go_loc;
  logic            w_go_ch;
  logic            w_fin;
  logic            w_abort;
  logic            w_tmo;
  logic            w_wr;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  logic            w_unused_ok;

  assign w_req = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                 (wbs.wbs_adr_i[31:28] == 4'h3);
  assign w_word  = wbs.wbs_adr_i[10:2];
  assign w_blk   = w_word[8:4];
  assign w_local = (w_blk == 5'd0);
  assign w_ch_ok = !w_local && ({1'b0, w_blk} <= NCH6);
  assign w_chsel = ONE << (w_blk - 5'd1);

  assign w_bmask = {{8{wbs.wbs_sel_i[3]}},
                    {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}},
                    {8{wbs.wbs_sel_i[0]}}};

  assign w_is_stat = w_local && (w_word[3:0] == 4'd0);
  assign w_is_pre  = w_local && (w_word[3:0] == 4'd1);
  assign w_is_msk  = w_local && (w_word[3:0] == 4'd2);

  always_comb begin
    w_loc_rd = '0;
    unique case (1'b1)
      w_is_stat: w_loc_rd = r_status;
      w_is_pre:  w_loc_rd = {24'd0, r_presc};
      w_is_msk:  w_loc_rd = r_mask;
      default:   w_loc_rd = '0;
    endcase
  end

  // r_valid is one-hot and held, so it doubles as the ack/data select
  assign w_sel_ack = |(ch_ack_i & r_valid);

  always_comb begin
    w_sel_dat = '0;
    for (int k = 0; k < N_CH; k++)
      if (r_valid[k]) w_sel_dat = ch_dat_i[k*DW +: DW];
  end

`ifdef SONAR_FABRIC_TIMEOUT_EN
  logic [TW-1:0] r_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_cnt <= '0;
    else if (r_state != S_CH_WAIT) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_go_loc = 1'b0;
    w_go_ch  = 1'b0;
    w_fin    = 1'b0;
    w_abort  = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_ch_ok) begin
            w_nxt   = S_CH_WAIT;
            w_go_ch = 1'b1;
          end else begin
            w_nxt    = S_DONE;
            w_go_loc = 1'b1;
          end
        end
      end
      S_CH_WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          w_nxt   = S_IDLE;
          w_abort = 1'b1;
        end else if (w_sel_ack) begin
          w_nxt = S_DONE;
          w_fin = 1'b1;
        end
`ifdef SONAR_FABRIC_TIMEOUT_EN
        else if (r_cnt == TW'(TIMEOUT - 1)) begin
          w_nxt = S_DONE;
          w_tmo = 1'b1;
        end
`endif
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_wr  = w_go_loc & wbs.wbs_we_i;
  assign w_set = 32'(cmp_i) | {w_tmo, 31'd0};
  assign w_clr = (w_wr && w_is_stat) ?
                 (wbs.wbs_dat_i & w_bmask) : 32'd0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_valid  <= '0;
      r_adr    <= '0;
      r_cdat   <= '0;
      r_strb   <= 1'b0;
      r_status <= '0;
      r_mask   <= '0;
      r_presc  <= 8'd49;
      r_irq    <= 1'b0;
    end else begin
      r_ack <= w_go_loc | w_fin | w_tmo;
      if (w_go_loc)
        r_dat <= wbs.wbs_we_i ? 32'd0 : w_loc_rd;
      else if (w_fin)
        r_dat <= {{(32-DW){w_sel_dat[DW-1]}}, w_sel_dat};
      else if (w_tmo)
        r_dat <= 32'hFFFF_FFFF;
      if (w_go_ch) begin
        r_valid <= w_chsel;
        r_adr   <= w_word[3:0];
        r_cdat  <= {wbs.wbs_dat_i[31],
                    wbs.wbs_dat_i[DW-2:0]};
        r_strb  <= wbs.wbs_we_i & wbs.wbs_sel_i[0];
      end else if (w_fin | w_abort | w_tmo) begin
        r_valid <= '0;
        r_adr   <= '0;
        r_cdat  <= '0;
        r_strb  <= 1'b0;
      end
      if (w_wr && w_is_pre && wbs.wbs_sel_i[0])
        r_presc <= wbs.wbs_dat_i[7:0];
      if (w_wr && w_is_msk)
        r_mask <= ((r_mask & ~w_bmask) |
                   (wbs.wbs_dat_i & w_bmask)) & MSK_BITS;
      // sticky set is applied after the W1C so a same-cycle set wins
      r_status <= ((r_status & ~w_clr) | w_set) & STAT_MASK;
      r_irq    <= |(r_status & r_mask & STAT_MASK);
    end
  end

`ifdef SONAR_FABRIC_TIMEOUT_EN
  assign w_unused_ok = ^{wbs.wbs_adr_i[27:11],
                         wbs.wbs_adr_i[1:0]};
`else
  assign w_unused_ok = ^{wbs.wbs_adr_i[27:11],
                         wbs.wbs_adr_i[1:0],
                         32'(TIMEOUT)};
`endif

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign ch_valid_o    = r_valid;
  assign ch_adr_o      = r_adr;
  assign ch_dat_o      = r_cdat;
  assign ch_strb_o     = r_strb;
  assign prescaler_o   = r_presc;
  assign irq_o         = r_irq;

endmodule
